bank_cmd_gate: RTL and testbench
================================

// Module: bank_cmd_gate
// PURPOSE
//  Per-bank command legality gate between the bank scheduler and the DRAM
//  command bus. It sits directly downstream of tP_counter and consumes its
//  tP_ba_counter/recode outputs, plus its own tRAS/tRC/tRFC counters.
//  It accepts one command per cycle via valid/ready and only accepts it when
//  the bank state and all timings allow. It also autonomously issues the
//  precharge implied by a RD/WR with auto-precharge.
// PARAMETERS
//  BANK_ID      0   bank index this instance serves (compared to cmd_bank)
//  BA_BITS      3   bank address width
//  CYCLE_TRAS   15  ACT->PRE minimum, cycles (loaded as CYCLE_TRAS-1)
//  CYCLE_TRC    20  ACT->ACT minimum, same bank
//  CYCLE_TRFC   44  REF->next command minimum
//  CODE_WR2PRE  1   recode value: write-to-precharge
//  CODE_PRE2ACT 2   recode value: precharge-to-active
//  CODE_ACT2RW  3   recode value: active-to-read/write
//  CODE_RD2PRE  4   recode value: read-to-precharge
//  CODE_PRE2REF 7   recode value: precharge-to-refresh
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous active-high reset
//  cmd_valid    in   1       scheduler command request
//  cmd_type     in   3       0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 REF; others illegal
//  cmd_bank     in   BA_BITS target bank
//  cmd_auto_pre in   1       RD/WR with auto-precharge
//  tp_cnt       in   5       tP_ba_counter from tP_counter (this bank)
//  recode       in   3       recode from tP_counter (this bank)
//  cmd_ready    out  1       combinational: command legal this cycle
//  issue_valid  out  1       registered one-cycle pulse: command issued
//  issue_cmd    out  3       issued command type (cmd_type encoding)
//  issue_ap     out  1       issued command carries/is auto-precharge
//  bank_open    out  1       registered: row open (state OPEN or AP_WAIT)
// BEHAVIOUR
//  - Reset: state=CLOSED; tras/trc/trfc counters=0; issue_valid=0,
//    issue_cmd=0, issue_ap=0, bank_open=0; cmd_ready=0 during rst.
//  - Accept condition: cmd_valid & cmd_ready & cmd_bank==BANK_ID. cmd_ready
//    is 0 when cmd_bank!=BANK_ID, cmd_type is NOP or illegal, or rst=1.
//  - tp_ok = (tp_cnt==0) | (recode not the code guarding the command).
//  - FSM states: CLOSED, OPEN, AP_WAIT, REFRESH.
//    CLOSED : ACT ready if tp_ok(PRE2ACT) & trc==0 -> OPEN; tras<=TRAS-1,
//             trc<=TRC-1. REF ready if tp_ok(PRE2REF) & trc==0 -> REFRESH,
//             trfc<=TRFC-1. PRE ready (no-op precharge, issued) -> stays.
//             RD/WR not ready.
//    OPEN   : RD ready if tp_ok(ACT2RW); WR ready if tp_ok(ACT2RW).
//             With cmd_auto_pre=1 -> AP_WAIT, else stay. PRE ready if
//             tras==0 & tp_ok(WR2PRE) & tp_ok(RD2PRE) -> CLOSED. ACT/REF not ready.
//    AP_WAIT: cmd_ready=0 for all commands. When tras==0 & tp_cnt==0, the
//             block issues an internal PRE (issue_cmd=4, issue_ap=1) -> CLOSED.
//    REFRESH: cmd_ready=0. When trfc==0 -> CLOSED (no issue pulse).
//  - Issue latency: accepted command appears on issue_* the next cycle.
//    issue_ap echoes cmd_auto_pre for RD/WR and is 0 for external ACT/PRE/REF.
//  - Counters are 6-bit saturating down-counters (trfc 7-bit). They
//    decrement every cycle when nonzero and reload only on ACT/REF issue.
//  - Simultaneous events: internal AP precharge and external commands cannot
//    collide, because ready=0 in AP_WAIT. The counter load takes precedence
//    over the decrement in the same cycle.
//  - Mid-operation reset: state returns to CLOSED, counters clear, and any
//    pending auto-precharge is dropped.
// TESTING
//  1 ACT at t0, tp_cnt driven from recode=CODE_ACT2RW counting 3..0 -> RD
//    ready only when tp_cnt==0; issue_valid pulse 1 cycle after accept.
//  2 ACT then PRE at +5 cycles (TRAS=15) -> ready=0 until tras==0 (cycle
//    15 after ACT); PRE accepted -> bank_open=0 next cycle.
//  3 WR with auto_pre=1, recode=CODE_WR2PRE, tp_cnt=10 -> cmd_ready=0 in
//    AP_WAIT; internal PRE issue_cmd=4, issue_ap=1 once tras==0 & tp_cnt==0.
//  4 REF from CLOSED with TRFC=44 -> cmd_ready=0 for 44 cycles, then ACT
//    accepted; no issue pulse on REFRESH exit.
//  5 cmd_bank!=BANK_ID or cmd_type=6 -> cmd_ready=0, no issue; RD to
//    CLOSED bank -> cmd_ready=0.
//  6 rst=1 asserted while in AP_WAIT -> next cycle CLOSED, bank_open=0,
//    no internal PRE is ever issued.

Source files
------------

// File: rtl/bank_cmd_gate_if.sv
// Scheduler-to-gate command channel: request, tP_counter timing inputs and issue outputs.
interface bank_cmd_gate_if #(
    parameter int unsigned BA_BITS = 3
);
    logic               cmd_valid;
    logic [2:0]         cmd_type;
    logic [BA_BITS-1:0] cmd_bank;
    logic               cmd_auto_pre;
    logic [4:0]         tp_cnt;
    logic [2:0]         recode;
    logic               cmd_ready;
    logic               issue_valid;
    logic [2:0]         issue_cmd;
    logic               issue_ap;
    logic               bank_open;

    modport master (
        output cmd_valid, cmd_type, cmd_bank, cmd_auto_pre, tp_cnt, recode,
        input  cmd_ready, issue_valid, issue_cmd, issue_ap, bank_open
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_bank, cmd_auto_pre, tp_cnt, recode,
        output cmd_ready, issue_valid, issue_cmd, issue_ap, bank_open
    );
endinterface

// File: rtl/bank_cmd_gate.sv
// Per-bank command legality gate: accepts a scheduler command only when bank state
// and tRAS/tRC/tRFC/tP timings allow, and issues the precharge implied by auto-precharge.
module bank_cmd_gate #(
    parameter int unsigned BANK_ID      = 0,
    parameter int unsigned BA_BITS      = 3,
    parameter int unsigned CYCLE_TRAS   = 15,
    parameter int unsigned CYCLE_TRC    = 20,
    parameter int unsigned CYCLE_TRFC   = 44,
    parameter int unsigned CODE_WR2PRE  = 1,
    parameter int unsigned CODE_PRE2ACT = 2,
    parameter int unsigned CODE_ACT2RW  = 3,
    parameter int unsigned CODE_RD2PRE  = 4,
    parameter int unsigned CODE_PRE2REF = 7
) (
    input  logic            clk,
    input  logic            rst,
    bank_cmd_gate_if.slave  bus
);
    localparam int unsigned TW  = 6;
    localparam int unsigned TFW = 7;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [2:0] RC_WR2PRE  = 3'(CODE_WR2PRE);
    localparam logic [2:0] RC_PRE2ACT = 3'(CODE_PRE2ACT);
    localparam logic [2:0] RC_ACT2RW  = 3'(CODE_ACT2RW);
    localparam logic [2:0] RC_RD2PRE  = 3'(CODE_RD2PRE);
    localparam logic [2:0] RC_PRE2REF = 3'(CODE_PRE2REF);

    localparam logic [TW-1:0]  TRAS_LOAD = TW'(CYCLE_TRAS - 1);
    localparam logic [TW-1:0]  TRC_LOAD  = TW'(CYCLE_TRC - 1);
    localparam logic [TFW-1:0] TRFC_LOAD = TFW'(CYCLE_TRFC - 1);

    typedef enum logic [1:0] {
        ST_CLOSED,
        ST_OPEN,
        ST_AP_WAIT,
        ST_REFRESH
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tras_q, tras_d;
    logic [TW-1:0]   trc_q, trc_d;
    logic [TFW-1:0]  trfc_q, trfc_d;
    logic            issue_valid_q, issue_valid_d;
    logic [2:0]      issue_cmd_q, issue_cmd_d;
    logic            issue_ap_q, issue_ap_d;
    logic            bank_open_q, bank_open_d;
    logic            ready_c;
    logic            accept_c;

    // tP guard: the running tP window only blocks the command whose recode it carries
    logic tp_zero, ok_wr2pre, ok_pre2act, ok_act2rw, ok_rd2pre, ok_pre2ref, bank_hit;
    assign tp_zero    = (bus.tp_cnt == 5'd0);
    assign ok_wr2pre  = tp_zero | (bus.recode != RC_WR2PRE);
    assign ok_pre2act = tp_zero | (bus.recode != RC_PRE2ACT);
    assign ok_act2rw  = tp_zero | (bus.recode != RC_ACT2RW);
    assign ok_rd2pre  = tp_zero | (bus.recode != RC_RD2PRE);
    assign ok_pre2ref = tp_zero | (bus.recode != RC_PRE2REF);
    assign bank_hit   = (bus.cmd_bank == BA_BITS'(BANK_ID));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLOSED;
            tras_q        <= '0;
            trc_q         <= '0;
            trfc_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_cmd_q   <= CMD_NOP;
            issue_ap_q    <= 1'b0;
            bank_open_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tras_q        <= tras_d;
            trc_q         <= trc_d;
            trfc_q        <= trfc_d;
            issue_valid_q <= issue_valid_d;
            issue_cmd_q   <= issue_cmd_d;
            issue_ap_q    <= issue_ap_d;
            bank_open_q   <= bank_open_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tras_d        = (tras_q != '0) ? tras_q - TW'(1)  : tras_q;
        trc_d         = (trc_q  != '0) ? trc_q  - TW'(1)  : trc_q;
        trfc_d        = (trfc_q != '0) ? trfc_q - TFW'(1) : trfc_q;
        ready_c       = 1'b0;
        accept_c      = 1'b0;
        issue_valid_d = 1'b0;
        issue_cmd_d   = CMD_NOP;
        issue_ap_d    = 1'b0;
        bank_open_d   = 1'b0;

        case (state_q)
            ST_CLOSED: begin
                case (bus.cmd_type)
                    CMD_ACT: ready_c = ok_pre2act & (trc_q == '0);
                    CMD_REF: ready_c = ok_pre2ref & (trc_q == '0);
                    CMD_PRE: ready_c = 1'b1;
                    default: ready_c = 1'b0;
                endcase
            end
            ST_OPEN: begin
                case (bus.cmd_type)
                    CMD_RD,
                    CMD_WR:  ready_c = ok_act2rw;
                    CMD_PRE: ready_c = (tras_q == '0) & ok_wr2pre & ok_rd2pre;
                    default: ready_c = 1'b0;
                endcase
            end
            ST_AP_WAIT: begin
                if ((tras_q == '0) && tp_zero) begin
                    state_d       = ST_CLOSED;
                    issue_valid_d = 1'b1;
                    issue_cmd_d   = CMD_PRE;
                    issue_ap_d    = 1'b1;
                end
            end
            ST_REFRESH: begin
                if (trfc_q == '0) begin
                    state_d = ST_CLOSED;
                end
            end
            default: state_d = ST_CLOSED;
        endcase

        ready_c  = ready_c & bank_hit & ~rst;
        accept_c = bus.cmd_valid & ready_c;

        // Counter loads override the free-running decrement
        if (accept_c) begin
            issue_valid_d = 1'b1;
            issue_cmd_d   = bus.cmd_type;
            case (bus.cmd_type)
                CMD_ACT: begin
                    state_d = ST_OPEN;
                    tras_d  = TRAS_LOAD;
                    trc_d   = TRC_LOAD;
                end
                CMD_REF: begin
                    state_d = ST_REFRESH;
                    trfc_d  = TRFC_LOAD;
                end
                CMD_PRE: state_d = ST_CLOSED;
                CMD_RD,
                CMD_WR: begin
                    issue_ap_d = bus.cmd_auto_pre;
                    if (bus.cmd_auto_pre) begin
                        state_d = ST_AP_WAIT;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        bank_open_d = (state_d == ST_OPEN) || (state_d == ST_AP_WAIT);
    end

    assign bus.cmd_ready   = ready_c;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_cmd   = issue_cmd_q;
    assign bus.issue_ap    = issue_ap_q;
    assign bus.bank_open   = bank_open_q;
endmodule

// File: tb/tb_bank_cmd_gate.sv
// Testbench for bank_cmd_gate: directed scenarios plus randomized traffic against a
// timestamp-based reference model of bank legality and issue behaviour.
module tb_bank_cmd_gate;
    localparam int TRAS = 15;
    localparam int TRC  = 20;
    localparam int TRFC = 44;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;
    localparam logic [2:0] C_REF = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_cmd_gate_if #(.BA_BITS(3)) bus ();

    bank_cmd_gate #(
        .BANK_ID(0), .BA_BITS(3), .CYCLE_TRAS(TRAS), .CYCLE_TRC(TRC), .CYCLE_TRFC(TRFC),
        .CODE_WR2PRE(1), .CODE_PRE2ACT(2), .CODE_ACT2RW(3), .CODE_RD2PRE(4), .CODE_PRE2REF(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: row/refresh/auto-precharge flags plus timestamps of last ACT/REF
    int       cyc     = 0;
    int       act_cyc = -100000;
    int       ref_cyc = -100000;
    bit       row_open = 1'b0;
    bit       ap_pend  = 1'b0;
    bit       ref_pend = 1'b0;
    bit       e_iv = 1'b0;
    logic [2:0] e_ic = 3'd0;
    bit       e_ia = 1'b0;

    function automatic bit tpok(input int code);
        return (bus.tp_cnt == 5'd0) || (bus.recode != 3'(code));
    endfunction

    function automatic bit m_ready();
        int since;
        since = cyc - act_cyc;
        if (rst || bus.cmd_bank != 3'd0) return 1'b0;
        if (ref_pend && (cyc - ref_cyc) <= TRFC) return 1'b0;
        if (ap_pend) return 1'b0;
        if (!row_open) begin
            case (bus.cmd_type)
                C_ACT:   return tpok(2) && since >= TRC;
                C_REF:   return tpok(7) && since >= TRC;
                C_PRE:   return 1'b1;
                default: return 1'b0;
            endcase
        end
        case (bus.cmd_type)
            C_RD, C_WR: return tpok(3);
            C_PRE:      return since >= TRAS && tpok(1) && tpok(4);
            default:    return 1'b0;
        endcase
    endfunction

    task automatic drive(input int v, input int t, input int b, input int ap,
                         input int tp, input int rc, input int r);
        @(negedge clk);
        rst              = r[0];
        bus.cmd_valid    = v[0];
        bus.cmd_type     = 3'(t);
        bus.cmd_bank     = 3'(b);
        bus.cmd_auto_pre = ap[0];
        bus.tp_cnt       = 5'(tp);
        bus.recode       = 3'(rc);
        #1;
    endtask

    // Advance one clock and update the model with what was presented this cycle
    task automatic tick();
        bit acc, fire, ap;
        logic [2:0] t;
        acc  = bus.cmd_valid && m_ready();
        fire = ap_pend && !rst && (cyc - act_cyc) >= TRAS && bus.tp_cnt == 5'd0;
        t    = bus.cmd_type;
        ap   = bus.cmd_auto_pre;
        @(posedge clk);
        e_iv = 1'b0; e_ic = 3'd0; e_ia = 1'b0;
        if (rst) begin
            row_open = 1'b0; ap_pend = 1'b0; ref_pend = 1'b0; act_cyc = -100000;
        end else if (fire) begin
            e_iv = 1'b1; e_ic = C_PRE; e_ia = 1'b1; row_open = 1'b0; ap_pend = 1'b0;
        end else if (acc) begin
            e_iv = 1'b1; e_ic = t;
            case (t)
                C_ACT: begin row_open = 1'b1; act_cyc = cyc; end
                C_REF: begin ref_pend = 1'b1; ref_cyc = cyc; end
                C_PRE: row_open = 1'b0;
                C_RD, C_WR: begin e_ia = ap; ap_pend = ap; end
                default: ;
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        drive(0, C_NOP, 0, 0, 0, 0, 1);
        tick();
        drive(0, C_NOP, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, C_ACT, 0, 0, 0, 0, 1);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b exp 0", bus.cmd_ready);
        end
        tick();
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got iv=%b cmd=%0d ap=%b open=%b exp all 0",
                     bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open);
        end
        drive(0, C_NOP, 0, 0, 0, 0, 0);
    endtask

    task automatic test_act_rd();
        do_reset();
        drive(1, C_ACT, 0, 0, 0, 0, 0);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL act_ready: got %b exp 1", bus.cmd_ready);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open} !== 6'b1_001_0_1) begin
            errors++;
            $display("FAIL act_issue: got iv=%b cmd=%0d ap=%b open=%b exp 1 1 0 1",
                     bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open);
        end
        for (int tp = 3; tp >= 0; tp--) begin
            drive(1, C_RD, 0, 0, tp, 3, 0);
            checks++;
            if (bus.cmd_ready !== 1'(tp == 0)) begin
                errors++; $display("FAIL rd_tp_ready tp=%0d: got %b exp %b", tp, bus.cmd_ready, tp == 0);
            end
            tick();
            checks++;
            if (bus.issue_valid !== 1'(tp == 0) || (tp == 0 && bus.issue_cmd !== C_RD)) begin
                errors++;
                $display("FAIL rd_issue tp=%0d: got iv=%b cmd=%0d exp iv=%b cmd=2",
                         tp, bus.issue_valid, bus.issue_cmd, tp == 0);
            end
        end
        drive(0, C_NOP, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (bus.issue_valid !== 1'b0) begin
            errors++; $display("FAIL rd_pulse_width: got iv=%b exp 0", bus.issue_valid);
        end
    endtask

    task automatic test_pre_tras();
        do_reset();
        drive(1, C_ACT, 0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= TRAS; k++) begin
            drive(1, C_PRE, 0, 0, 0, 0, 0);
            checks++;
            if (bus.cmd_ready !== 1'(k == TRAS)) begin
                errors++; $display("FAIL pre_tras_ready k=%0d: got %b exp %b", k, bus.cmd_ready, k == TRAS);
            end
            tick();
        end
        checks++;
        if ({bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open} !== 6'b1_100_0_0) begin
            errors++;
            $display("FAIL pre_issue: got iv=%b cmd=%0d ap=%b open=%b exp 1 4 0 0",
                     bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open);
        end
    endtask

    task automatic test_wr_ap();
        do_reset();
        drive(1, C_ACT, 0, 0, 0, 0, 0);
        tick();
        drive(1, C_WR, 0, 1, 0, 3, 0);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL wr_ap_ready: got %b exp 1", bus.cmd_ready);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open} !== 6'b1_011_1_1) begin
            errors++;
            $display("FAIL wr_ap_issue: got iv=%b cmd=%0d ap=%b open=%b exp 1 3 1 1",
                     bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open);
        end
        for (int k = 2; k <= TRAS; k++) begin
            drive(1, (k % 2 == 0) ? C_PRE : C_RD, 0, 0, (k <= 12) ? 12 - k : 0, 1, 0);
            checks++;
            if (bus.cmd_ready !== 1'b0) begin
                errors++; $display("FAIL ap_wait_ready k=%0d: got %b exp 0", k, bus.cmd_ready);
            end
            tick();
            checks++;
            if (k == TRAS) begin
                if ({bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open} !== 6'b1_100_1_0) begin
                    errors++;
                    $display("FAIL ap_pre_issue: got iv=%b cmd=%0d ap=%b open=%b exp 1 4 1 0",
                             bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open);
                end
            end else if (bus.issue_valid !== 1'b0 || bus.bank_open !== 1'b1) begin
                errors++;
                $display("FAIL ap_wait_hold k=%0d: got iv=%b open=%b exp 0 1", k, bus.issue_valid, bus.bank_open);
            end
        end
    endtask

    task automatic test_refresh();
        do_reset();
        drive(1, C_REF, 0, 0, 0, 0, 0);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL ref_ready: got %b exp 1", bus.cmd_ready);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open} !== 6'b1_101_0_0) begin
            errors++;
            $display("FAIL ref_issue: got iv=%b cmd=%0d ap=%b open=%b exp 1 5 0 0",
                     bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open);
        end
        for (int k = 1; k <= TRFC; k++) begin
            drive(1, C_ACT, 0, 0, 0, 0, 0);
            checks++;
            if (bus.cmd_ready !== 1'b0) begin
                errors++; $display("FAIL trfc_ready k=%0d: got %b exp 0", k, bus.cmd_ready);
            end
            tick();
            checks++;
            if (bus.issue_valid !== 1'b0) begin
                errors++; $display("FAIL trfc_issue k=%0d: got iv=%b exp 0", k, bus.issue_valid);
            end
        end
        drive(1, C_ACT, 0, 0, 0, 0, 0);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL post_ref_act_ready: got %b exp 1", bus.cmd_ready);
        end
        tick();
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_cmd !== C_ACT) begin
            errors++;
            $display("FAIL post_ref_act_issue: got iv=%b cmd=%0d exp 1 1", bus.issue_valid, bus.issue_cmd);
        end
    endtask

    task automatic test_illegal();
        int types[7] = '{1, 6, 7, 0, 2, 3, 5};
        int banks[7] = '{1, 0, 0, 0, 0, 0, 3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1, types[i], banks[i], 0, 0, 0, 0);
            checks++;
            if (bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL illegal_ready type=%0d bank=%0d: got %b exp 0", types[i], banks[i], bus.cmd_ready);
            end
            tick();
            checks++;
            if (bus.issue_valid !== 1'b0) begin
                errors++; $display("FAIL illegal_issue type=%0d: got iv=%b exp 0", types[i], bus.issue_valid);
            end
        end
    endtask

    task automatic test_rst_ap();
        do_reset();
        drive(1, C_ACT, 0, 0, 0, 0, 0);
        tick();
        drive(1, C_WR, 0, 1, 0, 3, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, C_NOP, 0, 0, 5, 1, 0);
            tick();
        end
        checks++;
        if (bus.bank_open !== 1'b1) begin
            errors++; $display("FAIL rst_ap_open_before: got %b exp 1", bus.bank_open);
        end
        drive(0, C_NOP, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (bus.bank_open !== 1'b0 || bus.issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_ap_after: got open=%b iv=%b exp 0 0", bus.bank_open, bus.issue_valid);
        end
        for (int k = 0; k < 30; k++) begin
            drive(0, C_NOP, 0, 0, 0, 0, 0);
            tick();
            checks++;
            if (bus.issue_valid !== 1'b0) begin
                errors++; $display("FAIL rst_ap_dropped k=%0d: got iv=%b exp 0", k, bus.issue_valid);
            end
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 4) != 0,
                  $urandom % 8,
                  (($urandom % 5) == 0) ? $urandom % 8 : 0,
                  $urandom % 2,
                  (($urandom % 3) == 0) ? $urandom % 4 : 0,
                  $urandom % 8,
                  (($urandom % 250) == 0));
            exp_rdy = m_ready();
            checks++;
            if (bus.cmd_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready n=%0d type=%0d bank=%0d: got %b exp %b",
                         n, bus.cmd_type, bus.cmd_bank, bus.cmd_ready, exp_rdy);
            end
            tick();
            checks++;
            if (bus.issue_valid !== e_iv || bus.bank_open !== row_open ||
                (e_iv && (bus.issue_cmd !== e_ic || bus.issue_ap !== e_ia))) begin
                errors++;
                $display("FAIL rand_outputs n=%0d: got iv=%b cmd=%0d ap=%b open=%b exp iv=%b cmd=%0d ap=%b open=%b",
                         n, bus.issue_valid, bus.issue_cmd, bus.issue_ap, bus.bank_open,
                         e_iv, e_ic, e_ia, row_open);
            end
        end
    endtask

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_type     = C_NOP;
        bus.cmd_bank     = 3'd0;
        bus.cmd_auto_pre = 1'b0;
        bus.tp_cnt       = 5'd0;
        bus.recode       = 3'd0;
        test_reset();
        test_act_rd();
        test_pre_tras();
        test_wr_ap();
        test_refresh();
        test_illegal();
        test_rst_ap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
